// File: rtl/data_mem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus an MMIO page holding a
// free-running cycle counter and an output FIFO drained by a valid/ready consumer.
module data_mem_mmio #(
    parameter int          DEPTH      = 256,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteMem,
    output logic [31:0] Memout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        bus_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
    localparam logic [7:0]  FIFO_FULL = 8'(FIFO_DEPTH);

    logic [31:0]   ram_q [DEPTH];
    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [31:0]   cycle_q, cycle_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          aligned_s, ram_hit_s, cyc_hit_s, odat_hit_s, ostat_hit_s, miss_s;
    logic [AW-1:0] ram_idx_s;
    logic          full_s, empty_s, push_req_s, push_s, pop_s;
    logic [31:0]   status_s;

    assign aligned_s   = (DataAddr[1:0] == 2'b00);
    assign ram_hit_s   = aligned_s && (DataAddr < RAM_BYTES);
    assign cyc_hit_s   = aligned_s && (DataAddr == MMIO_BASE);
    assign odat_hit_s  = aligned_s && (DataAddr == MMIO_BASE + 32'd4);
    assign ostat_hit_s = aligned_s && (DataAddr == MMIO_BASE + 32'd8);
    assign miss_s      = !(ram_hit_s || cyc_hit_s || odat_hit_s || ostat_hit_s);
    assign ram_idx_s   = DataAddr[AW+1:2];
    assign bus_err     = (MemRead || MemWrite) && miss_s;

    assign full_s     = (count_q == FIFO_FULL);
    assign empty_s    = (count_q == 8'd0);
    assign out_valid  = !empty_s;
    assign out_data   = empty_s ? 32'd0 : fifo_q[rd_ptr_q];
    assign pop_s      = out_valid && out_ready;
    assign push_req_s = MemWrite && odat_hit_s;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign push_s     = push_req_s && (!full_s || pop_s);
    assign status_s   = {full_s, empty_s, overflow_q, 21'd0, count_q};
    assign cycle_d    = cycle_q + 32'd1;

    // Next-state for FIFO pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 8'd1;
            2'b01:   count_d = count_q - 8'd1;
            default: count_d = count_q;
        endcase
        if (MemWrite && ostat_hit_s) begin
            overflow_d = 1'b0;
        end else if (push_req_s && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Load data mux; unmapped and non-read cycles return zero.
    always_comb begin
        Memout = 32'd0;
        if (MemRead) begin
            if (ram_hit_s) begin
                Memout = ram_q[ram_idx_s];
            end else if (cyc_hit_s) begin
                Memout = cycle_q;
            end else if (ostat_hit_s) begin
                Memout = status_s;
            end else begin
                Memout = 32'd0;
            end
        end else begin
            Memout = 32'd0;
        end
    end

    // Control state; reset flushes the FIFO and restarts the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q    <= 32'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 8'd0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // RAM store; deliberately independent of reset so a store in the reset cycle lands.
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit_s) begin
            ram_q[ram_idx_s] <= WriteMem;
        end
    end

    // FIFO storage; pushes during reset are discarded along with the flush.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fifo_q[wr_ptr_q] <= WriteMem;
        end
    end

endmodule
